// File: rtl/aes_axis_pkg.sv
// aes_axis_pkg: shared types, widths and round-robin helper for the AES stream fabric
package aes_axis_pkg;

   typedef enum logic {IDLE, LOCKED} arb_state_t;

   localparam int AXIS_TDATA_WIDTH = 64;

   function automatic int rr_next(input logic [7:0] req, input int last, input int n);
      int idx;
      rr_next = 0;
      for (int k = 8; k >= 1; k--) begin
         if (k <= n) begin
            idx = (last + k) % n;
            if (req[3'(idx)]) rr_next = idx;
         end
      end
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotate-priority encoder, first request after last, wrapping modulo N
module rr_pick
   import aes_axis_pkg::*;
#(
   parameter int N = 2,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] last,
   output logic [W-1:0] grant,
   output logic         any_req
);

   // scan last+1, last+2, ... so the previous owner has lowest priority
   always_comb begin
      grant   = W'(rr_next(8'(req), int'(last), N));
      any_req = |req;
   end

endmodule

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-locked round-robin merge of NUM_INPUTS AXI-Stream sources
module axis_rr_arbiter
   import aes_axis_pkg::*;
#(
   parameter int NUM_INPUTS  = 2,
   parameter int TDATA_WIDTH = AXIS_TDATA_WIDTH
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [NUM_INPUTS-1:0]                   s_tvalid,
   output logic [NUM_INPUTS-1:0]                   s_tready,
   input  logic [NUM_INPUTS*TDATA_WIDTH-1:0]       s_tdata,
   input  logic [NUM_INPUTS*TDATA_WIDTH/8-1:0]     s_tkeep,
   input  logic [NUM_INPUTS-1:0]                   s_tlast,
   input  logic [NUM_INPUTS-1:0]                   s_tuser,
   output logic                                    m_tvalid,
   input  logic                                    m_tready,
   output logic [TDATA_WIDTH-1:0]                  m_tdata,
   output logic [TDATA_WIDTH/8-1:0]                m_tkeep,
   output logic                                    m_tlast,
   output logic                                    m_tuser,
   output logic [$clog2(NUM_INPUTS)-1:0]           grant_id,
   output logic                                    busy
);

   localparam int GW = $clog2(NUM_INPUTS);
   localparam int KW = TDATA_WIDTH / 8;

   arb_state_t state, state_nx;
   logic [GW-1:0] last_grant, last_nx, grant_nx, pick;
   logic any_req, end_pkt;

   rr_pick #(.N(NUM_INPUTS), .W(GW)) u_pick (
      .req     (s_tvalid),
      .last    (last_grant),
      .grant   (pick),
      .any_req (any_req)
   );

   // owner is chosen in IDLE and held until its tlast handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= GW'(NUM_INPUTS - 1);
         grant_id   <= '0;
      end else begin
         state      <= state_nx;
         last_grant <= last_nx;
         grant_id   <= grant_nx;
      end
   end

   // zero-latency pass-through of the owner's slice; everything idle otherwise
   always_comb begin
      busy     = state == LOCKED;
      m_tvalid = busy & s_tvalid[grant_id];
      m_tdata  = busy ? s_tdata[grant_id*TDATA_WIDTH +: TDATA_WIDTH] : '0;
      m_tkeep  = busy ? s_tkeep[grant_id*KW +: KW] : '0;
      m_tlast  = busy & s_tlast[grant_id];
      m_tuser  = busy & s_tuser[grant_id];
      s_tready = (busy & m_tready) ? NUM_INPUTS'(1) << grant_id : '0;
      end_pkt  = m_tvalid & m_tready & m_tlast;
      state_nx = busy ? (end_pkt ? IDLE : LOCKED) : (any_req ? LOCKED : IDLE);
      grant_nx = (!busy && any_req) ? pick : grant_id;
      last_nx  = end_pkt ? grant_id : last_grant;
   end

endmodule

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
- Packet-granular round-robin arbiter sharing one AXI-Stream datapath, such as the AES core input, between NUM_INPUTS requester streams.
- A grant is locked from the first beat of a packet until its tlast handshake, so packets are never interleaved.
- Sits between per-requester stream sources (key/IV loaders, data DMA channels) and the single AES stream sink.
- Carries tdata/tkeep/tlast/tuser unchanged and exposes the current owner on grant_id.

Parameters:
- NUM_INPUTS, 2, number of slave streams; legal range 2..8.
- TDATA_WIDTH, 64, stream data width in bits; multiple of 8.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- s_tvalid  in  NUM_INPUTS  per-input valid; bit i is input i.
- s_tready  out  NUM_INPUTS  per-input ready.
- s_tdata  in  NUM_INPUTS*TDATA_WIDTH  input i in slice [i*TDATA_WIDTH +: TDATA_WIDTH].
- s_tkeep  in  NUM_INPUTS*TDATA_WIDTH/8  per-input byte enables, same slicing rule.
- s_tlast  in  NUM_INPUTS  per-input end of packet.
- s_tuser  in  NUM_INPUTS  per-input sideband bit.
- m_tvalid  out  1  merged stream valid.
- m_tready  in  1  downstream ready.
- m_tdata  out  TDATA_WIDTH  merged data.
- m_tkeep  out  TDATA_WIDTH/8  merged byte enables.
- m_tlast  out  1  merged end of packet.
- m_tuser  out  1  merged sideband bit.
- grant_id  out  $clog2(NUM_INPUTS)  index of the locked input; valid while busy is 1.
- busy  out  1  1 while in state LOCKED.

Behaviour:
- One clock domain (clk). Reset is synchronous, active-high (rst).
- Reset values:
  - state = IDLE, last_grant = NUM_INPUTS-1 (input 0 has first priority).
  - grant_id = 0, busy = 0.
  - s_tready = 0, m_tvalid = 0.
  - m_tdata, m_tkeep, m_tlast, m_tuser = 0.
- State IDLE:
  - All s_tready = 0; m_tvalid = 0; m payload driven 0.
  - If any s_tvalid is 1, select the first asserted input scanning last_grant+1, last_grant+2, ... modulo NUM_INPUTS.
  - Register the selection into grant_id and go to LOCKED on the next edge.
  - If no s_tvalid is set, stay in IDLE.
- State LOCKED, combinational pass-through, zero latency:
  - m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser = slice grant_id of the s_* inputs.
  - s_tready[grant_id] = m_tready; all other s_tready = 0.
  - On a handshake beat (m_tvalid & m_tready) with m_tlast = 1: last_grant <= grant_id, go to IDLE.
  - Otherwise stay in LOCKED, including when the granted input drops tvalid mid-packet. The lock holds and no other input is serviced.
- Arbitration cost:
  - Exactly one IDLE bubble cycle between consecutive packets.
  - Maximum sustained throughput is L/(L+1) for L-beat packets.
- Fairness: with all inputs continuously requesting, grants rotate 0,1,...,N-1,0,...
  - No input waits more than NUM_INPUTS-1 packets.
- Single-beat packet (tlast on the first beat): LOCKED for one cycle, then IDLE.
- s_tvalid asserting in the IDLE cycle while another input's packet just ended:
  - Considered that same cycle.
  - Priority still starts from the new last_grant+1.
- rst during LOCKED:
  - Immediate return to reset state on the next edge.
  - The partial packet is abandoned. The arbiter does not emit tlast; recovery is the system's responsibility.
- Stall safety:
  - Output slice and grant_id must not change between the first beat and the tlast handshake.
  - Payload is held stable by the source per AXI-S rules.
- No tkeep or tuser interpretation. Width rule: grant_id index arithmetic wraps modulo NUM_INPUTS, including non-power-of-two values (e.g. 3).

Decomposition:
- Shared package aes_axis_pkg holds:
  - arb_state_t enum {IDLE, LOCKED}.
  - Function rr_next(req, last, n) returning the next grant index.
  - Constant AXIS_TDATA_WIDTH = 64.
- Sub-module: rr_pick, a combinational rotate-priority encoder (req vector + last_grant -> grant index, any_req).
  - Unit-testable separately.
  - Remainder of the block is the FSM and muxes in axis_rr_arbiter.

Test Plan:
1. After reset, only input 1 sends a 3-beat packet 0xA1,0xA2,0xA3 with m_tready=1:
   - 1-cycle bubble, then m_tdata A1,A2,A3 on consecutive cycles with grant_id=1.
   - tlast on A3; busy returns 0 the next cycle.
2. Both inputs continuously valid with 2-beat packets (input 0: 0x10,0x11; input 1: 0x20,0x21):
   - Output order is 10,11,20,21,10,11,...
   - Exactly one bubble between packets.
   - grant_id alternates 0,1.
3. Backpressure: during a 4-beat packet on input 0, m_tready=0 for 3 cycles mid-packet, with input 1 valid throughout:
   - m_tdata holds value; s_tready = 2'b00.
   - No input-1 beat appears before input 0's tlast.
4. Gap in the granted source: input 0 drops s_tvalid for 2 cycles after beat 1 while input 1 is valid:
   - m_tvalid=0 for those cycles, grant_id stays 0.
   - Input 1 is granted only after input 0's tlast.
5. NUM_INPUTS=3, all inputs sending 1-beat packets: grants 0,1,2,0; last_grant wraps correctly, with each packet taking 2 cycles.
6. Assert rst for 1 cycle in the middle of beat 2 of 4 on input 0:
   - Next cycle busy=0, m_tvalid=0, s_tready=0.
   - The next grant goes to input 0 (last_grant reset to N-1).
